// File: rtl/shift_add_multiplier_pkg.sv
// Purpose : shared constants and FSM state encoding for the shift-add multiplier.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package shift_add_multiplier_pkg;

    // One add/shift step per multiplier bit.
    localparam int STEPS = 8;
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    // 2'd3 is unused; the FSM falls back to IDLE if it ever appears.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// Purpose : combinational ripple-carry adder with carry-out, no carry-in.
// Latency : combinational (0 cycles).
// Backpressure: none; output follows inputs.
// Ports   : i1, i2 addends; s sum; c_out carry out of the top bit.
module shift_add_multiplier_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    output logic [WIDTH-1:0] s,
    output logic             c_out
);

    logic carry;

    always_comb begin
        carry = 1'b0;
        s     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i]  = i1[i] ^ i2[i] ^ carry;
            carry = (i1[i] & i2[i]) | (carry & (i1[i] ^ i2[i]));
        end
        c_out = carry;
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Purpose : sequential 8x8 unsigned shift-and-add multiplier, 16-bit product.
// Latency : start sampled at t0, product/done registered at t8, idle again at t9.
// Backpressure: start is only honoured in IDLE; ignored while busy or done.
// Ports   : clk, rst (sync, active-high); start/a/b request; busy, done, product status/result.
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    import shift_add_multiplier_pkg::*;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     sum;
    logic                 cout;
    logic [2*WIDTH-1:0]   step_res;
    logic                 last_step;

    shift_add_multiplier_adder #(.WIDTH(WIDTH)) u_adder (
        .i1    (acc_hi_q),
        .i2    (mcand_q),
        .s     (sum),
        .c_out (cout)
    );

    // The carry lands in acc_hi[7]; without it 0xFF*0xFF and similar go wrong.
    assign step_res  = acc_lo_q[0] ? {cout, sum, acc_lo_q[WIDTH-1:1]}
                                   : {1'b0, acc_hi_q, acc_lo_q[WIDTH-1:1]};
    assign last_step = (cnt_q == LAST_CNT);

    // State register (and all datapath registers).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    acc_lo_d = b;
                    acc_hi_d = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                end
            end
            RUN: begin
                {acc_hi_d, acc_lo_d} = step_res;
                cnt_d  = cnt_q + 1'b1;
                busy_d = ~last_step;
                if (last_step) begin
                    product_d = step_res;
                    done_d    = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
